// File: rtl/csi_ltf_estimator.sv
// csi_ltf_estimator: averages pairs of L-LTF FFT frames per bin and applies the LTF sign to produce CSI
module csi_ltf_estimator #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  sync_in,
    input  logic                  fft_axis_tvalid,
    input  logic                  fft_axis_tlast,
    input  logic [DATA_WIDTH-1:0] fft_re_axis_tdata,
    input  logic [DATA_WIDTH-1:0] fft_im_axis_tdata,
    output logic                  fft_axis_tready,
    output logic                  csi_axis_tvalid,
    output logic                  csi_axis_tlast,
    output logic [DATA_WIDTH-1:0] csi_re_axis_tdata,
    output logic [DATA_WIDTH-1:0] csi_im_axis_tdata,
    input  logic                  csi_axis_tready,
    output logic                  frame_err
);
    // L_k in FFT bin order: L_NZ marks occupied bins, L_NEG marks the -1 bins (bit k = bin k)
    localparam logic [63:0] L_NZ  = {26'h3ff_ffff, 11'd0, 26'h3ff_ffff, 1'b0};
    localparam logic [63:0] L_NEG = {26'b00001010011000000101001100, 11'd0,
                                     26'b00001010110011111010100110, 1'b0};
    localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {FIRST, SECOND} state_t;

    state_t                         r_state, w_state_nxt;
    logic [5:0]                     r_cnt, w_cnt_nxt;
    logic [2*DATA_WIDTH-1:0]        r_buf [64];
    logic                           r_valid, r_last, r_err;
    logic [DATA_WIDTH-1:0]          r_re, r_im;
    logic                           w_acc, w_bin63, w_bad, w_emit;
    logic [2*DATA_WIDTH-1:0]        w_rd;
    logic signed [DATA_WIDTH:0]     w_sum_re, w_sum_im;
    logic signed [DATA_WIDTH-1:0]   w_avg_re, w_avg_im, w_csi_re, w_csi_im;

    // frame A is always accepted; frame B only when the output register can take the result
    assign fft_axis_tready = (r_state == FIRST) || !r_valid || csi_axis_tready;
    assign w_acc   = fft_axis_tvalid && fft_axis_tready;
    assign w_bin63 = r_cnt == 6'd63;
    assign w_bad   = w_acc && (fft_axis_tlast != w_bin63);
    assign w_emit  = w_acc && (r_state == SECOND) && !sync_in;

    // one extra bit keeps the pair sum exact; the floor halving always fits back in DATA_WIDTH
    assign w_rd     = r_buf[r_cnt];
    assign w_sum_re = {w_rd[2*DATA_WIDTH-1], w_rd[2*DATA_WIDTH-1:DATA_WIDTH]}
                    + {fft_re_axis_tdata[DATA_WIDTH-1], fft_re_axis_tdata};
    assign w_sum_im = {w_rd[DATA_WIDTH-1], w_rd[DATA_WIDTH-1:0]}
                    + {fft_im_axis_tdata[DATA_WIDTH-1], fft_im_axis_tdata};
    assign w_avg_re = DATA_WIDTH'(w_sum_re >>> 1);
    assign w_avg_im = DATA_WIDTH'(w_sum_im >>> 1);
    // negating the most negative value would wrap, so it clamps to the positive maximum
    assign w_csi_re = !L_NZ[r_cnt] ? '0 : !L_NEG[r_cnt] ? w_avg_re :
                      (w_avg_re == S_MIN) ? S_MAX : -w_avg_re;
    assign w_csi_im = !L_NZ[r_cnt] ? '0 : !L_NEG[r_cnt] ? w_avg_im :
                      (w_avg_im == S_MIN) ? S_MAX : -w_avg_im;

    assign csi_axis_tvalid   = r_valid;
    assign csi_axis_tlast    = r_last;
    assign csi_re_axis_tdata = r_re;
    assign csi_im_axis_tdata = r_im;
    assign frame_err         = r_err;

    // next state and bin counter: sync wins, then framing errors, then normal frame progress
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (sync_in || w_bad) begin
            w_state_nxt = FIRST;
            w_cnt_nxt   = '0;
        end else if (w_acc) begin
            w_cnt_nxt = r_cnt + 6'd1;
            if (w_bin63) w_state_nxt = (r_state == FIRST) ? SECOND : FIRST;
        end
    end

    // state, counter and the framing-error pulse (suppressed when sync re-arms the pairing)
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= FIRST;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_bad && !sync_in;
        end
    end

    // frame A capture into LUTRAM; contents are deliberately never cleared
    always_ff @(posedge clk_in) begin
        if (w_acc && (r_state == FIRST) && !sync_in) r_buf[r_cnt] <= {fft_re_axis_tdata, fft_im_axis_tdata};
    end

    // output register: loads on each frame B beat, a tlast error closes the frame early
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_re    <= '0;
            r_im    <= '0;
        end else if (w_emit) begin
            r_valid <= 1'b1;
            r_last  <= w_bin63 || fft_axis_tlast;
            r_re    <= w_csi_re;
            r_im    <= w_csi_im;
        end else if (csi_axis_tready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_csi_ltf_estimator.sv
// tb_csi_ltf_estimator: directed scoreboard bench for the LTF-pair CSI estimator
module tb_csi_ltf_estimator;
    localparam int DW = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b1;
    logic          sync_in = 1'b0;
    logic          fft_axis_tvalid = 1'b0;
    logic          fft_axis_tlast = 1'b0;
    logic [DW-1:0] fft_re_axis_tdata = '0;
    logic [DW-1:0] fft_im_axis_tdata = '0;
    logic          csi_axis_tready = 1'b1;
    logic          fft_axis_tready, csi_axis_tvalid, csi_axis_tlast, frame_err;
    logic [DW-1:0] csi_re_axis_tdata, csi_im_axis_tdata;

    csi_ltf_estimator #(.DATA_WIDTH(DW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .sync_in(sync_in),
        .fft_axis_tvalid(fft_axis_tvalid), .fft_axis_tlast(fft_axis_tlast),
        .fft_re_axis_tdata(fft_re_axis_tdata), .fft_im_axis_tdata(fft_im_axis_tdata),
        .fft_axis_tready(fft_axis_tready), .csi_axis_tvalid(csi_axis_tvalid),
        .csi_axis_tlast(csi_axis_tlast), .csi_re_axis_tdata(csi_re_axis_tdata),
        .csi_im_axis_tdata(csi_im_axis_tdata), .csi_axis_tready(csi_axis_tready),
        .frame_err(frame_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int            bin;
        logic [2*DW:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_err = 0;
    bit   bp_en = 0;
    int   a_re[64], a_im[64], b_re[64], b_im[64];
    int   lo[26] = '{1,-1,-1,1,1,-1,1,-1,1,-1,-1,-1,-1,-1,1,1,-1,-1,1,-1,1,-1,1,1,1,1};
    int   hi[26] = '{1,1,-1,-1,1,1,-1,1,-1,1,1,1,1,1,1,-1,-1,1,1,-1,1,-1,1,1,1,1};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    function automatic int sgn(input int k);
        if (k >= 1 && k <= 26) return lo[k-1];
        if (k >= 38 && k <= 63) return hi[k-38];
        return 0;
    endfunction

    function automatic logic [2*DW:0] model(input int k, ar, ai, br, bi, input bit last);
        int r, i, s;
        s = sgn(k);
        r = (ar + br) >>> 1;
        i = (ai + bi) >>> 1;
        if (s == 0) begin
            r = 0;
            i = 0;
        end else if (s < 0) begin
            r = -r;
            i = -i;
        end
        if (r > 32767) r = 32767;
        if (i > 32767) i = 32767;
        return {r[DW-1:0], i[DW-1:0], last};
    endfunction

    // random output backpressure when enabled
    always @(posedge clk_in) begin
        #1;
        csi_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor: pops the scoreboard on every output handshake, checks stall stability, counts frame_err
    logic [2*DW:0] prev;
    bit            stall = 0;
    always @(negedge clk_in) begin
        if (!rst_n_in) stall = 0;
        else begin
            if (frame_err) n_err++;
            if (stall) check("csi held while stalled",
                             {csi_axis_tvalid, csi_re_axis_tdata, csi_im_axis_tdata, csi_axis_tlast}, {1'b1, prev});
            if (csi_axis_tvalid && csi_axis_tready) begin
                check("csi beat expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check($sformatf("csi bin %0d {re,im,last}", e.bin),
                          {csi_re_axis_tdata, csi_im_axis_tdata, csi_axis_tlast}, e.v);
                end
            end
            stall = csi_axis_tvalid && !csi_axis_tready;
            prev  = {csi_re_axis_tdata, csi_im_axis_tdata, csi_axis_tlast};
        end
    end

    // called at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic send_beat(input int re, im, input bit last, sync, chk_rdy, output bit ok);
        int t = 0;
        fft_axis_tvalid   = 1'b1;
        fft_axis_tlast    = last;
        fft_re_axis_tdata = DW'(re);
        fft_im_axis_tdata = DW'(im);
        sync_in           = sync;
        ok = 0;
        while (!ok && t < 1000) begin
            @(negedge clk_in);
            if (chk_rdy && t == 0) check("fft_axis_tready in frame A", fft_axis_tready, 1);
            ok = fft_axis_tready;
            t++;
            @(posedge clk_in);
            #1;
        end
        fft_axis_tvalid = 1'b0;
        fft_axis_tlast  = 1'b0;
        sync_in         = 1'b0;
        if (!ok) check("input beat accepted before timeout", ok, 1);
    endtask

    task automatic send_frame(input bit is_b, input int n, input int last_at);
        bit ok;
        for (int k = 0; k < n; k++) begin
            send_beat(is_b ? b_re[k] : a_re[k], is_b ? b_im[k] : a_im[k], k == last_at, 1'b0, !is_b, ok);
            if (ok && is_b) sb.push_back('{k, model(k, a_re[k], a_im[k], b_re[k], b_im[k], k == 63 || k == last_at)});
        end
    endtask

    task automatic run_pair();
        send_frame(1'b0, 64, 63);
        send_frame(1'b1, 64, 63);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk_in);
            #1;
            t++;
        end
        repeat (3) @(posedge clk_in);
        #1;
        check(name, sb.size(), 0);
    endtask

    task automatic fill(input int ar, ai, br, bi);
        for (int k = 0; k < 64; k++) begin
            a_re[k] = ar; a_im[k] = ai; b_re[k] = br; b_im[k] = bi;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 64; k++) begin
            a_re[k] = int'($urandom_range(0, 65535)) - 32768;
            a_im[k] = int'($urandom_range(0, 65535)) - 32768;
            b_re[k] = int'($urandom_range(0, 65535)) - 32768;
            b_im[k] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic pulse_sync();
        sync_in = 1'b1;
        @(posedge clk_in);
        #1;
        sync_in = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int e0;
        bit ok;
        #2 rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset csi_axis_tvalid", csi_axis_tvalid, 0);
        check("reset csi_axis_tlast", csi_axis_tlast, 0);
        check("reset csi data", {csi_re_axis_tdata, csi_im_axis_tdata}, 0);
        check("reset frame_err", frame_err, 0);
        check("reset fft_axis_tready", fft_axis_tready, 1);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // constant frames: bin1 (101,-41), bin2 (-101,41), nulls (0,0), bin63 carries tlast
        fill(100, -40, 102, -42);
        run_pair();
        drain("basic pair drained");

        // floor rounding on bin 1, then negation saturation on bin 2
        fill(0, 0, 0, 0);
        a_re[1] = 3; a_im[1] = -3;
        run_pair();
        drain("rounding pair drained");
        fill(0, 0, 0, 0);
        a_re[2] = -32768; a_im[2] = -32768; b_re[2] = -32768; b_im[2] = -32768;
        run_pair();
        drain("saturation pair drained");

        // random data under 50% output backpressure
        bp_en = 1;
        for (int p = 0; p < 4; p++) begin
            fill_rand();
            run_pair();
        end
        drain("backpressure pairs drained");
        bp_en = 0;
        @(posedge clk_in);
        #1;

        // framing errors: early tlast in A, missing tlast in A, early tlast in B
        e0 = n_err;
        fill_rand();
        send_frame(1'b0, 41, 40);
        repeat (3) @(posedge clk_in);
        #1;
        check("frame_err after tlast at bin 40", n_err - e0, 1);
        send_frame(1'b0, 64, -1);
        repeat (3) @(posedge clk_in);
        #1;
        check("frame_err after missing tlast", n_err - e0, 2);
        fill_rand();
        run_pair();
        drain("pair after framing errors drained");
        send_frame(1'b0, 64, 63);
        send_frame(1'b1, 11, 10);
        drain("truncated frame B drained");
        check("frame_err after early tlast in B", n_err - e0, 3);
        fill_rand();
        run_pair();
        drain("pair after B error drained");
        check("no extra frame_err on good pairs", n_err - e0, 3);

        // sync re-arms pairing and drops a coincident beat without flagging an error
        e0 = n_err;
        fill_rand();
        send_frame(1'b0, 64, 63);
        pulse_sync();
        fill_rand();
        run_pair();
        drain("pair after sync drained");
        send_frame(1'b0, 10, -1);
        send_beat(1234, -1234, 1'b1, 1'b1, 1'b1, ok);
        fill_rand();
        run_pair();
        drain("pair after sync beat in A drained");
        send_frame(1'b0, 64, 63);
        send_frame(1'b1, 5, -1);
        send_beat(777, -777, 1'b1, 1'b1, 1'b0, ok);
        fill_rand();
        run_pair();
        drain("pair after sync beat in B drained");
        check("sync never raises frame_err", n_err - e0, 0);

        // async reset in the middle of frame B
        fill_rand();
        send_frame(1'b0, 64, 63);
        send_frame(1'b1, 20, -1);
        #1 rst_n_in = 1'b0;
        #1;
        check("csi_axis_tvalid drops on async reset", csi_axis_tvalid, 0);
        check("fft_axis_tready during reset", fft_axis_tready, 1);
        sb.delete();
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        fill_rand();
        run_pair();
        drain("pair after reset drained");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/csi_ltf_estimator.md
Name: csi_ltf_estimator

Overview:
- Sits directly downstream of the 64-point AXIS FFT wrapper in the CSI extractor.
- Consumes pairs of FFT output frames for the two 802.11a/g L-LTF symbols. For each bin it averages the pair and multiplies by the known LTF sign L_k, producing one 64-bin CSI frame per pair.
- Output is an AXIS stream in FFT bin order; its consumer is the CSI DMA/packetiser.

Parameters:
- DATA_WIDTH, 16, width of each signed real/imag component on input and output.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- sync_in  input  1  single-cycle pulse that re-arms pairing; the next frame is treated as LTF symbol A.
- fft_axis_tvalid  input  1  input beat valid.
- fft_axis_tlast  input  1  marks bin 63 of an FFT frame.
- fft_re_axis_tdata  input  DATA_WIDTH  signed real part of the bin.
- fft_im_axis_tdata  input  DATA_WIDTH  signed imaginary part of the bin.
- fft_axis_tready  output  1  input ready.
- csi_axis_tvalid  output  1  output beat valid.
- csi_axis_tlast  output  1  marks the last beat of a CSI frame.
- csi_re_axis_tdata  output  DATA_WIDTH  signed real part of the CSI.
- csi_im_axis_tdata  output  DATA_WIDTH  signed imaginary part of the CSI.
- csi_axis_tready  input  1  output ready.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst_n_in=0, asynchronous): state FIRST, bin counter 0. All outputs 0, except fft_axis_tready, which is 1 after reset in FIRST. Any in-flight output beat is dropped.
- Beat accepted when fft_axis_tvalid && fft_axis_tready. The bin counter (6-bit) increments per accepted beat and wraps 63->0.
- State FIRST:
  - fft_axis_tready=1 unconditionally.
  - Each accepted beat writes {re,im} into a 64x(2*DATA_WIDTH) buffer at the bin counter address. The buffer is asynchronous-read LUTRAM.
  - No output is produced.
  - Accepted beat at bin 63 with tlast -> SECOND.
- State SECOND:
  - fft_axis_tready = ~csi_axis_tvalid | csi_axis_tready (combinational).
  - For an accepted beat at bin k: s = buf[k] + in, computed at DATA_WIDTH+1 bits per component. avg = s >>> 1 (arithmetic, floor), which always fits DATA_WIDTH.
  - Output per L_k:
    - L_k=+1: avg.
    - L_k=-1: -avg, with -(-2^(DATA_WIDTH-1)) saturating to 2^(DATA_WIDTH-1)-1.
    - L_k=0: (0,0).
  - Output is registered: valid the cycle after acceptance, so latency is 1 cycle. csi_axis_tlast=1 only for bin 63.
  - Output is held stable while csi_axis_tvalid && !csi_axis_tready.
  - Accepted beat at bin 63 with tlast -> FIRST.
- L_k table, FFT order:
  - bin 0 = 0.
  - bins 1..26 = +,-,-,+,+,-,+,-,+,-,-,-,-,-,+,+,-,-,+,-,+,-,+,+,+,+.
  - bins 27..37 = 0.
  - bins 38..63 = +,+,-,-,+,+,-,+,-,+,+,+,+,+,+,-,-,+,+,-,+,-,+,+,+,+.
- Framing error is either tlast on an accepted beat with counter != 63, or counter == 63 without tlast. On error:
  - frame_err pulses for 1 cycle and the counter resets to 0.
  - State goes to FIRST.
  - In SECOND, the offending beat is still emitted with csi_axis_tlast=1 so the output frame closes.
- sync_in (synchronous, sampled every cycle):
  - Forces FIRST with counter 0.
  - A beat accepted in the same cycle is discarded; it is neither written nor emitted.
  - An output beat already registered is still delivered.
  - sync_in has priority over framing-error detection; frame_err is not pulsed.
- Buffer contents are not cleared by reset or sync. Every frame A overwrites all 64 entries before they are read.

Test Plan:
- Frame A all bins (100,-40), frame B all bins (102,-42), csi_axis_tready=1 -> 64 output beats. Required values: bin1 (101,-41); bin2 (-101,41); bin0 and bins 27..37 (0,0); bin63 (101,-41) with tlast. tlast is set on no other beat.
- Rounding and saturation, run as separate pairs on bin 1, then on bin 2:
  - bin1 A=(3,-3), B=(0,0) -> (1,-2).
  - bin2 A=B=(-32768,-32768) -> (32767,32767).
- Backpressure: random 50% csi_axis_tready across 4 pairs -> output matches the scoreboard with no loss or duplication; data is stable while stalled; fft_axis_tready stays 1 throughout every frame A.
- Framing error: tlast at bin 40 in frame A -> frame_err pulses once and no output appears; the next good pair produces correct CSI.
- sync_in: pulse after a complete frame A -> the next frame is treated as A and no output appears until the frame after it; a sync coincident with an accepted beat drops that beat.
- Async reset at bin 20 of frame B -> csi_axis_tvalid falls immediately; the following pair yields correct, complete output.
